// File: rtl/lc3_pkg.sv
// Shared LC-3 controller types: opcode and memory-state encodings plus opcode class helpers.
package lc3_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
    OP_JSR  = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7,
    OP_RTI  = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB,
    OP_JMP  = 4'hC, OP_RES = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    MEM_READ     = 2'd0,
    MEM_INDIRECT = 2'd1,
    MEM_WRITE    = 2'd2,
    MEM_IDLE     = 2'd3
  } mem_state_t;

  function automatic opcode_t op_of(input logic [15:0] instr);
    return opcode_t'(instr[15:12]);
  endfunction

  function automatic logic is_alu(input opcode_t op);
    return op inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
  endfunction

  function automatic logic is_load(input opcode_t op);
    return op inside {OP_LD, OP_LDR, OP_LDI};
  endfunction

  function automatic logic is_store(input opcode_t op);
    return op inside {OP_ST, OP_STR, OP_STI};
  endfunction

  function automatic logic is_ctl(input opcode_t op);
    return op inside {OP_BR, OP_JMP};
  endfunction

endpackage

// File: rtl/lc3_controller_if.sv
// Controller <-> datapath bundle; master is the controller, slave is the datapath side.
interface lc3_controller_if;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] Instr_dout;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic [2:0]  psr;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [1:0]  mem_state;

  modport master (
    input  complete_instr, complete_data, Instr_dout, IR, IR_Exec, NZP, psr,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
           bypass_mem_1, bypass_mem_2, mem_state
  );

  modport slave (
    output complete_instr, complete_data, Instr_dout, IR, IR_Exec, NZP, psr,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
           bypass_mem_1, bypass_mem_2, mem_state
  );
endinterface

// File: rtl/lc3_hazard_unit.sv
// Pure-combinational operand-forward detector: matches execute's destination against decode's sources.
module lc3_hazard_unit
  import lc3_pkg::*;
(
  input  logic [15:0] i_ir,
  input  logic [15:0] i_ir_exec,
  output logic        o_alu_1,
  output logic        o_alu_2,
  output logic        o_mem_1,
  output logic        o_mem_2
);

  opcode_t w_op_dec;
  opcode_t w_op_exec;
  logic    w_src1_hit;
  logic    w_src2_hit;
  logic    w_unused_bits;

  assign w_op_dec  = op_of(i_ir);
  assign w_op_exec = op_of(i_ir_exec);

  // SR1 lives in [8:6] for these opcodes; SR2 only exists in register-mode ADD/AND.
  assign w_src1_hit = (w_op_dec inside {OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR, OP_JMP})
                      && (i_ir[8:6] == i_ir_exec[11:9]);
  assign w_src2_hit = (w_op_dec inside {OP_ADD, OP_AND}) && !i_ir[5]
                      && (i_ir[2:0] == i_ir_exec[11:9]);

  assign o_alu_1 = is_alu(w_op_exec)  && w_src1_hit;
  assign o_alu_2 = is_alu(w_op_exec)  && w_src2_hit;
  assign o_mem_1 = is_load(w_op_exec) && w_src1_hit;
  assign o_mem_2 = is_load(w_op_exec) && w_src2_hit;

  assign w_unused_bits = ^{i_ir[11:9], i_ir[4:3], i_ir_exec[8:0]};

endmodule

// File: rtl/lc3_controller.sv
// LC-3 pipeline controller: fill/stall sequencing, memory FSM, branch resolve, forwarding selects.
// Optional LC3_CTRL_MEM_BYPASS_EN forwards load results; otherwise a load-use match stalls one cycle.
module lc3_controller
  import lc3_pkg::*;
#(
  parameter int CTL_STALL = 3
)(
  input  logic             clk,
  input  logic             reset,
  lc3_controller_if.master bus
);

  localparam logic [2:0] LP_STALL = 3'(CTL_STALL);

  mem_state_t r_mem_state;
  logic [2:0] r_valid;
  logic [2:0] r_count;
  logic       r_run;

  opcode_t w_op_fetch;
  opcode_t w_op_exec;
  logic    w_mem_busy, w_haz_stall, w_ctl_load;
  logic    w_alu_1, w_alu_2, w_mem_1, w_mem_2;
  logic    w_upd, w_fetch, w_dec, w_exe, w_wb;
  logic    w_unused_fetch;

  assign w_op_fetch     = op_of(bus.Instr_dout);
  assign w_op_exec      = op_of(bus.IR_Exec);
  assign w_mem_busy     = (r_mem_state != MEM_IDLE);
  assign w_ctl_load     = bus.complete_instr && is_ctl(w_op_fetch);
  assign w_unused_fetch = ^bus.Instr_dout[11:0];

  lc3_hazard_unit u_hazard (
    .i_ir      (bus.IR),
    .i_ir_exec (bus.IR_Exec),
    .o_alu_1   (w_alu_1),
    .o_alu_2   (w_alu_2),
    .o_mem_1   (w_mem_1),
    .o_mem_2   (w_mem_2)
  );

`ifdef LC3_CTRL_MEM_BYPASS_EN
  assign w_haz_stall      = 1'b0;
  assign bus.bypass_mem_1 = reset & w_mem_1;
  assign bus.bypass_mem_2 = reset & w_mem_2;
`else
  logic r_haz_q;

  // One bubble per load-use match; r_haz_q lets the pipeline move on the following cycle.
  assign w_haz_stall      = (w_mem_1 | w_mem_2) & ~w_mem_busy & ~r_haz_q;
  assign bus.bypass_mem_1 = 1'b0;
  assign bus.bypass_mem_2 = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_haz_q <= 1'b0;
    else        r_haz_q <= w_haz_stall;
  end
`endif

  assign bus.bypass_alu_1 = reset & w_alu_1;
  assign bus.bypass_alu_2 = reset & w_alu_2;
  assign bus.br_taken     = reset & ((w_op_exec == OP_JMP) ||
                                     ((w_op_exec == OP_BR) && ((bus.NZP & bus.psr) != 3'b000)));
  assign bus.mem_state    = r_mem_state;

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_state <= MEM_IDLE;
      r_count     <= '0;
      r_valid     <= '0;
      r_run       <= 1'b0;
    end else begin
      r_run <= 1'b1;
      case (r_mem_state)
        MEM_IDLE: begin
          if (is_load(w_op_exec))
            r_mem_state <= (w_op_exec == OP_LDI) ? MEM_INDIRECT : MEM_READ;
          else if (is_store(w_op_exec))
            r_mem_state <= (w_op_exec == OP_STI) ? MEM_INDIRECT : MEM_WRITE;
        end
        // Execute is frozen while busy, so IR_Exec still names the indirect op here.
        MEM_INDIRECT: if (bus.complete_data)
          r_mem_state <= (w_op_exec == OP_STI) ? MEM_WRITE : MEM_READ;
        default: if (bus.complete_data) r_mem_state <= MEM_IDLE;
      endcase
      if (!w_mem_busy) begin
        if (r_count != 3'd0) r_count <= r_count - 3'd1;
        else if (w_ctl_load) r_count <= LP_STALL;
      end
      if (r_run && !w_mem_busy && !w_haz_stall)
        r_valid <= {r_valid[1:0], 1'b1};
    end
  end

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_upd   = 1'b0;
    w_fetch = 1'b0;
    w_dec   = 1'b0;
    w_exe   = 1'b0;
    w_wb    = 1'b0;
    if (w_mem_busy) begin
      w_wb = (r_mem_state == MEM_READ) && bus.complete_data;
    end else if (w_haz_stall) begin
      w_wb = r_valid[2];
    end else begin
      w_exe = r_valid[1];
      w_wb  = r_valid[2];
      if (r_count != 3'd0) begin
        w_upd = (r_count == 3'd1);
        w_dec = r_valid[0] && (r_count == LP_STALL);
      end else begin
        w_dec   = r_valid[0];
        w_fetch = r_run && bus.complete_instr;
        w_upd   = r_run && bus.complete_instr;
      end
    end
  end

  assign bus.enable_updatePC  = w_upd;
  assign bus.enable_fetch     = w_fetch;
  assign bus.enable_decode    = w_dec;
  assign bus.enable_execute   = w_exe;
  assign bus.enable_writeback = w_wb;

endmodule

// File: tb/tb_lc3_controller.sv
// Self-checking bench for lc3_controller: directed scenarios plus randomized memory-op and forwarding checks.
module tb_lc3_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  lc3_controller_if bus ();

  lc3_controller #(.CTL_STALL(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.complete_instr = 1'b1;
    bus.complete_data  = 1'b0;
    bus.Instr_dout     = 16'h1000;
    bus.IR             = 16'h0000;
    bus.IR_Exec        = 16'h1000;
    bus.NZP            = 3'b000;
    bus.psr            = 3'b000;
  endtask

  function automatic logic [3:0] front();
    return {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode, bus.enable_execute};
  endfunction

  function automatic logic [3:0] bypass_out();
    return {bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1, bus.bypass_mem_2};
  endfunction

  // Reference forwarding rules, straight from the opcode/field definitions.
  function automatic logic [3:0] ref_bypass(input logic [15:0] ir, input logic [15:0] ir_ex);
    int  dop = int'(ir[15:12]);
    int  eop = int'(ir_ex[15:12]);
    bit  ex_alu = eop inside {1, 5, 9, 14};
    bit  ex_ld  = eop inside {2, 6, 10};
    bit  s1 = (dop inside {1, 5, 9, 6, 7, 12}) && (ir[8:6] == ir_ex[11:9]);
    bit  s2 = (dop inside {1, 5}) && (ir[5] == 1'b0) && (ir[2:0] == ir_ex[11:9]);
    bit  m1 = 1'b0;
    bit  m2 = 1'b0;
`ifdef LC3_CTRL_MEM_BYPASS_EN
    m1 = ex_ld && s1;
    m2 = ex_ld && s2;
`else
    m1 = ex_ld && 1'b0;
    m2 = ex_ld && 1'b0;
`endif
    return {ex_alu && s1, ex_alu && s2, m1, m2};
  endfunction

  function automatic logic ref_br(input logic [15:0] ir_ex, input logic [2:0] nzp, input logic [2:0] psr);
    return (ir_ex[15:12] == 4'd12) || ((ir_ex[15:12] == 4'd0) && ((nzp & psr) != 3'd0));
  endfunction

  // Expected mem_state visits for one memory instruction.
  task automatic push_path(input int op);
    case (op)
      2, 6:    exp_q.push_back(0);
      10:      begin exp_q.push_back(1); exp_q.push_back(0); end
      3, 7:    exp_q.push_back(2);
      default: begin exp_q.push_back(1); exp_q.push_back(2); end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mem_ops[6] = '{2, 6, 10, 3, 7, 11};
    idle_inputs();
    reset = 1'b0;
    repeat (2) cyc();

    // Reset state, with inputs that would otherwise raise br_taken and bypasses.
    bus.IR_Exec = 16'hC000; bus.NZP = 3'b111; bus.psr = 3'b111;
    #1;
    check("rst_mem_state", 16'(bus.mem_state), 16'd3);
    check("rst_front", 16'(front()), 16'h0);
    check("rst_wb", 16'(bus.enable_writeback), 16'd0);
    check("rst_br", 16'(bus.br_taken), 16'd0);
    bus.IR_Exec = 16'h1261; bus.IR = 16'h1441;
    #1;
    check("rst_bypass", 16'(bypass_out()), 16'h0);
    idle_inputs();
    reset = 1'b1;

    // Pipeline fill after release.
    for (int k = 1; k <= 4; k++) begin
      cyc(); #1;
      check("fill_front", 16'(front()), 16'({1'b1, 1'b1, k >= 2, k >= 3}));
      check("fill_wb", 16'(bus.enable_writeback), 16'(k >= 4));
    end

    // ALU forwarding.
    cyc();
    bus.IR_Exec = 16'h1261; bus.IR = 16'h1441;
    #1;
    check("alu_fwd_reg", 16'({bus.bypass_alu_1, bus.bypass_alu_2}), 16'b11);
    bus.IR = 16'h1460;
    #1;
    check("alu_fwd_imm", 16'({bus.bypass_alu_1, bus.bypass_alu_2}), 16'b10);
    idle_inputs();

    // Load-use: forward or one-cycle bubble, then the LDR itself occupies READ.
    cyc();
    bus.IR_Exec = 16'h6240; bus.IR = 16'h1441;
    #1;
`ifdef LC3_CTRL_MEM_BYPASS_EN
    check("ldu_bypass_mem_1", 16'(bus.bypass_mem_1), 16'd1);
    check("ldu_front", 16'(front()), 16'hF);
`else
    check("ldu_bypass_mem_1", 16'(bus.bypass_mem_1), 16'd0);
    check("ldu_front", 16'(front()), 16'h0);
    check("ldu_wb", 16'(bus.enable_writeback), 16'd1);
`endif
    cyc();
    bus.IR = 16'h0000; bus.complete_data = 1'b1; bus.IR_Exec = 16'h1000;
    #1;
    check("ldr_read", 16'(bus.mem_state), 16'd0);
    check("ldr_read_wb", 16'(bus.enable_writeback), 16'd1);
    cyc();
    bus.complete_data = 1'b0;
    #1;
    check("ldr_idle", 16'(bus.mem_state), 16'd3);

    // LDI with two held cycles, then completions.
    cyc();
    bus.IR_Exec = 16'hA000;
    #1;
    check("ldi_a_state", 16'(bus.mem_state), 16'd3);
    cyc(); #1;
    check("ldi_b_state", 16'(bus.mem_state), 16'd1);
    check("ldi_b_front", 16'(front()), 16'h0);
    cyc(); #1;
    check("ldi_c_state", 16'(bus.mem_state), 16'd1);
    cyc();
    bus.complete_data = 1'b1;
    #1;
    check("ldi_d_state", 16'(bus.mem_state), 16'd1);
    check("ldi_d_wb", 16'(bus.enable_writeback), 16'd0);
    cyc(); #1;
    check("ldi_e_state", 16'(bus.mem_state), 16'd0);
    check("ldi_e_front", 16'(front()), 16'h0);
    check("ldi_e_wb", 16'(bus.enable_writeback), 16'd1);
    bus.IR_Exec = 16'h1000;
    cyc();
    bus.complete_data = 1'b0;
    #1;
    check("ldi_f_state", 16'(bus.mem_state), 16'd3);
    check("ldi_f_front", 16'(front()), 16'hF);

    // Randomized memory ops with random completion timing.
    for (int i = 0; i < 16; i++) begin
      int op = mem_ops[$urandom_range(0, 5)];
      int guard = 0;
      logic [11:0] lo = 12'($urandom);
      cyc();
      bus.IR_Exec = {4'(op), lo};
      push_path(op);
      cyc();
      while (exp_q.size() > 0 && guard < 64) begin
        bus.complete_data = 1'($urandom_range(0, 1));
        #1;
        check("rnd_mem_state", 16'(bus.mem_state), 16'(exp_q[0]));
        check("rnd_mem_front", 16'(front()), 16'h0);
        check("rnd_mem_wb", 16'(bus.enable_writeback), 16'(exp_q[0] == 0 && bus.complete_data));
        if (bus.complete_data) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) bus.IR_Exec = 16'h1000;
        end
        cyc();
        guard++;
      end
      if (guard >= 64) begin
        check("rnd_mem_timeout", 16'd1, 16'd0);
        exp_q.delete();
      end
      bus.complete_data = 1'b0;
      bus.IR_Exec = 16'h1000;
      #1;
      check("rnd_mem_idle", 16'(bus.mem_state), 16'd3);
    end

    // Control-flow stall with a taken BRnzp.
    cyc();
    bus.Instr_dout = 16'h0E02; bus.IR_Exec = 16'h0E02; bus.psr = 3'b010; bus.NZP = 3'b111;
    #1;
    check("ctl_front0", 16'(front()), 16'hF);
    check("ctl_br", 16'(bus.br_taken), 16'd1);
    cyc();
    bus.Instr_dout = 16'h1000;
    #1;
    check("ctl_front_c3", 16'(front()), 16'h3);
    check("ctl_br_c3", 16'(bus.br_taken), 16'd1);
    cyc(); #1;
    check("ctl_front_c2", 16'(front()), 16'h1);
    cyc(); #1;
    check("ctl_front_c1", 16'(front()), 16'h9);
    cyc(); #1;
    check("ctl_front_done", 16'(front()), 16'hF);
    bus.complete_instr = 1'b0;
    #1;
    check("no_instr_front", 16'(front()), 16'h3);
    bus.complete_instr = 1'b1; bus.NZP = 3'b101;
    #1;
    check("br_not_taken", 16'(bus.br_taken), 16'd0);
    bus.IR_Exec = 16'hC000;
    #1;
    check("jmp_taken", 16'(bus.br_taken), 16'd1);
    idle_inputs();

    // Reset asserted during a WRITE.
    cyc();
    bus.IR_Exec = 16'h3000;
    cyc(); #1;
    check("st_write", 16'(bus.mem_state), 16'd2);
    reset = 1'b0;
    #1;
    check("st_async_rst", 16'(bus.mem_state), 16'd3);
    check("st_rst_front", 16'(front()), 16'h0);
    bus.IR_Exec = 16'h1000;
    cyc();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      check("st_no_write", 16'(bus.mem_state), 16'd3);
    end

    // Randomized forwarding and branch-resolution decode.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ir, ir_ex;
      logic [2:0]  nzp, psr;
      cyc();
      ir = 16'($urandom); ir_ex = 16'($urandom);
      nzp = 3'($urandom); psr = 3'($urandom);
      if (i % 4 == 0) ir_ex = {4'h1, ir_ex[11:0]};
      if (i % 4 == 1) ir = {4'h1, ir_ex[11:9], ir_ex[11:9], 1'b0, 2'b00, ir_ex[11:9]};
      bus.IR = ir; bus.IR_Exec = ir_ex; bus.NZP = nzp; bus.psr = psr;
      #1;
      check("rnd_bypass", 16'(bypass_out()), 16'(ref_bypass(ir, ir_ex)));
      check("rnd_br", 16'(bus.br_taken), 16'(ref_br(ir_ex, nzp, psr)));
      idle_inputs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_controller.md
LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 Parameter CTL_STALL, default 3, sets the control-flow stall length in cycles (legal 3..7).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 complete_instr  in  1  instruction memory returned Instr_dout this cycle.
REQ-005 complete_data  in  1  data memory access finished this cycle.
REQ-006 Instr_dout  in  16  instruction currently being fetched.
REQ-007 IR / IR_Exec  in  16 each  instruction in decode / in execute.
REQ-008 NZP / psr  in  3 each  branch condition from execute / writeback condition codes.
REQ-009 enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback  out  1 each  stage enables.
REQ-010 br_taken  out  1  PC loads branch/jump target.
REQ-011 bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2  out  1 each  operand forward selects.
REQ-012 mem_state  out  2  0 READ, 1 INDIRECT, 2 WRITE, 3 IDLE.

Function
REQ-013 Pipeline fill: 3-bit valid shift register, shifted in with 1 each cycle while not stalled. enable_decode=v[0], enable_execute=v[1], enable_writeback=v[2].
REQ-014 Memory FSM on IR_Exec opcode when entering from IDLE:
- LD/LDR: READ->IDLE.
- LDI: INDIRECT->READ->IDLE.
- ST/STR: WRITE->IDLE.
- STI: INDIRECT->WRITE->IDLE.
REQ-015 A non-IDLE state advances only on complete_data=1 and otherwise holds.
REQ-016 While mem_state!=3, outputs are: enable_updatePC=enable_fetch=enable_decode=enable_execute=0; enable_writeback=1 only in READ with complete_data=1.
REQ-017 Control-flow stall: if Instr_dout is BR(0000) or JMP(1100), complete_instr=1, counter=0 and mem_state=3, then the counter loads CTL_STALL on the next edge and decrements each non-memory-stalled cycle.
REQ-018 While counter!=0:
- enable_fetch=0.
- enable_updatePC=1 only when counter==1.
- enable_decode=1 only at counter==CTL_STALL.
REQ-019 br_taken=1 combinationally when IR_Exec is JMP, or IR_Exec is BR and (NZP & psr)!=0; otherwise 0.
REQ-020 complete_instr=0 with counter=0 and mem IDLE forces enable_updatePC=enable_fetch=0.
REQ-021 bypass_alu_1=1 when all hold:
- IR_Exec is ADD/AND/NOT/LEA;
- IR is ADD/AND/NOT/LDR/STR/JMP;
- IR[8:6]==IR_Exec[11:9].
REQ-022 bypass_alu_2=1 when IR_Exec is an ALU op, IR is ADD/AND with IR[5]=0, and IR[2:0]==IR_Exec[11:9].
REQ-023 bypass_mem_1/2 use the same register-match rules as REQ-021/022 but with IR_Exec being LD/LDR/LDI.
REQ-024 A simultaneous memory op and control-flow stall is resolved by memory FSM priority; the stall counter freezes until IDLE.
REQ-025 All outputs are a combinational decode of registered state and inputs, with no combinational input-to-state loops.

Reset
REQ-026 Reset low forces: mem_state=3, counter=0, valid=000, all enables=0, br_taken=0, bypasses=0.
REQ-027 Reset asserted mid-FSM or mid-stall aborts immediately with no pending store.
REQ-028 On the first edge after release, enable_updatePC=enable_fetch=1.

Configuration
REQ-029 With LC3_CTRL_MEM_BYPASS_EN defined, bypass_mem_1/2 behave per REQ-023.
REQ-030 Without LC3_CTRL_MEM_BYPASS_EN, bypass_mem_1/2 are tied to 0, and a REQ-023 match inserts one stall cycle with all enables 0 except enable_writeback.

Structure
REQ-031 Package lc3_pkg holds: opcode enum (4-bit), mem_state enum (2-bit), and is_alu/is_load/is_store/is_ctl functions.
REQ-032 Sub-module lc3_hazard_unit is the pure-combinational bypass detector (REQ-021..023).

Verification
REQ-033 Reset low for 2 cycles, then release: cycle 1 has updatePC=fetch=1 and decode=0; decode, execute and writeback rise on successive cycles.
REQ-034 IR_Exec=LDI (0xA000) with complete_data held 0 for 2 cycles, then 1 each step: mem_state 3->1(hold 3 cycles)->0->3, front enables 0 throughout.
REQ-035 Instr_dout=0x0E02 (BRnzp) with CTL_STALL=3 and psr=010, NZP=111: fetch=0 for 3 cycles, updatePC=1 in the 3rd, br_taken=1 while IR_Exec=0x0E02.
REQ-036 IR_Exec=0x1261 (ADD R1), IR=0x1441 (ADD R2,R1,R1): bypass_alu_1=1, bypass_alu_2=1; IR=0x1460 (imm): bypass_alu_2=0.
REQ-037 IR_Exec=0x6240 (LDR R1), IR=0x1441: macro defined gives bypass_mem_1=1; undefined gives bypass_mem_1=0 plus a one-cycle stall.
REQ-038 Reset asserted during WRITE: mem_state=3 asynchronously, and no WRITE seen after release.
